// File: rtl/vga_timing_pkg.sv
// Purpose: shared raster-timing constants and types for the sprite path.
//   Holds the default 640x480@60 timing, the derived line/frame totals and
//   the 10-bit position type used by vga_timing_gen, blob and pixel_arbiter.
// Ports: none (package).
package vga_timing_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    typedef logic [9:0] pos_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Purpose: bundle of raster-timing outputs fanned out to the blobs and pins.
// Signals:
//   clk25en      pixel enable, qualifies every other signal
//   curr_x_pos   horizontal position
//   curr_y_pos   vertical position
//   blank        outside the visible area
//   h_sync       horizontal sync pin level
//   v_sync       vertical sync pin level
//   frame_start  one-clk pulse on the move to (0,0)
// Modports: master (timing generator drives), slave (consumers sample).
interface vga_timing_if;
    import vga_timing_pkg::*;

    logic clk25en;
    pos_t curr_x_pos;
    pos_t curr_y_pos;
    logic blank;
    logic h_sync;
    logic v_sync;
    logic frame_start;

    modport master (
        output clk25en, curr_x_pos, curr_y_pos, blank, h_sync, v_sync, frame_start
    );

    modport slave (
        input clk25en, curr_x_pos, curr_y_pos, blank, h_sync, v_sync, frame_start
    );

endinterface

// File: rtl/vga_timing_gen_clk_en_div.sv
// Purpose: clock prescaler producing a registered 1-in-DIV enable.
// Ports:
//   clk     in   system clock
//   reset   in   synchronous, active-high
//   en_out  out  high for one clk in every DIV clks, first in cycle DIV after reset
module clk_en_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic en_out
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] DIV_LAST = W'(DIV - 1);

    logic [W-1:0] div_q, div_d;
    logic         en_q, en_d;

    // Next-state for the divide counter and its terminal-count enable.
    always_comb begin
        div_d = div_q + W'(1);
        en_d  = 1'b0;
        if (div_q == DIV_LAST) begin
            div_d = {W{1'b0}};
            en_d  = 1'b1;
        end else begin
            en_d  = 1'b0;
        end
    end

    // Counter and enable registers; reset overrides counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= {W{1'b0}};
            en_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            en_q  <= en_d;
        end
    end

    assign en_out = en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose: raster-timing generator. Divides clk into the pixel enable,
//   runs the x/y pixel counters and decodes blank, syncs and frame_start.
//   Every output is registered on the same edge as x/y, so decode and
//   position are always mutually consistent.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high
//   vif    master modport of vga_timing_if (all timing outputs)
module vga_timing_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FP      = vga_timing_pkg::H_FP,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BP      = vga_timing_pkg::H_BP,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FP      = vga_timing_pkg::V_FP,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BP      = vga_timing_pkg::V_BP,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    vga_timing_if.master vif
);
    import vga_timing_pkg::*;

    localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
        end
        if (CLK_DIV < 2) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be at least 2");
        end
    endgenerate

    localparam pos_t H_LAST   = pos_t'(H_TOT - 1);
    localparam pos_t V_LAST   = pos_t'(V_TOT - 1);
    localparam pos_t H_VIS    = pos_t'(H_VISIBLE);
    localparam pos_t V_VIS    = pos_t'(V_VISIBLE);
    localparam pos_t HS_START = pos_t'(H_VISIBLE + H_FP);
    localparam pos_t HS_END   = pos_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam pos_t VS_START = pos_t'(V_VISIBLE + V_FP);
    localparam pos_t VS_END   = pos_t'(V_VISIBLE + V_FP + V_SYNC);

    logic en_s;
    pos_t x_q, x_d;
    pos_t y_q, y_d;
    logic blank_q, blank_d;
    logic h_sync_q, h_sync_d;
    logic v_sync_q, v_sync_d;
    logic frame_start_q, frame_start_d;

    clk_en_div #(
        .DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .en_out (en_s)
    );

    // Raster advance and decode; decode uses the next-state x/y so it lands
    // on the same edge as the position it describes.
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        blank_d       = blank_q;
        h_sync_d      = h_sync_q;
        v_sync_d      = v_sync_q;
        frame_start_d = 1'b0;
        if (en_s) begin
            if (x_q == H_LAST) begin
                x_d = 10'd0;
                if (y_q == V_LAST) begin
                    y_d = 10'd0;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
                y_d = y_q;
            end
            blank_d       = (x_d >= H_VIS) || (y_d >= V_VIS);
            h_sync_d      = ((x_d >= HS_START) && (x_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
            v_sync_d      = ((y_d >= VS_START) && (y_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
            frame_start_d = (x_d == 10'd0) && (y_d == 10'd0);
        end else begin
            frame_start_d = 1'b0;
        end
    end

    // Output registers; reset abandons any partial line immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            blank_q       <= 1'b0;
            h_sync_q      <= ~SYNC_POL;
            v_sync_q      <= ~SYNC_POL;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            blank_q       <= blank_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vif.clk25en     = en_s;
    assign vif.curr_x_pos  = x_q;
    assign vif.curr_y_pos  = y_q;
    assign vif.blank       = blank_q;
    assign vif.h_sync      = h_sync_q;
    assign vif.v_sync      = v_sync_q;
    assign vif.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance (a) and a small
// high-active-sync instance (b). A cycle-indexed reference model feeds a
// scoreboard each clock; a table of hand-computed checkpoints and a few
// counting windows cover the line/frame corners and mid-frame reset.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       en;
        logic [9:0] x;
        logic [9:0] y;
        logic       blank;
        logic       hs;
        logic       vs;
        logic       fs;
    } exp_t;

    typedef struct {
        int   c;
        exp_t e;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    vga_timing_if ifa ();
    vga_timing_if ifb ();

    vga_timing_gen dut_a (
        .clk   (clk),
        .reset (reset),
        .vif   (ifa)
    );

    vga_timing_gen #(
        .CLK_DIV   (2),
        .H_VISIBLE (8),
        .H_FP      (1),
        .H_SYNC    (2),
        .H_BP      (1),
        .V_VISIBLE (4),
        .V_FP      (1),
        .V_SYNC    (1),
        .V_BP      (1),
        .SYNC_POL  (1'b1)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .vif   (ifb)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    exp_t qa[$];
    exp_t qb[$];

    // Reference: state after c clock edges since reset, derived from the
    // number of pixel enables seen rather than from counters.
    function automatic exp_t model(int c, int div, int hv, int hf, int hsw, int hb,
                                   int vv, int vf, int vsw, int vb, bit pol);
        exp_t e;
        int ht, vt, p, x, y;
        bit stepped;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        e.en = 1'b0; e.x = 10'd0; e.y = 10'd0; e.blank = 1'b0;
        e.hs = ~pol; e.vs = ~pol; e.fs = 1'b0;
        if (c > 0) begin
            e.en    = (c >= div) && (c % div == 0);
            p       = (c - 1) / div;
            x       = p % ht;
            y       = (p / ht) % vt;
            e.x     = 10'(x);
            e.y     = 10'(y);
            e.blank = (x >= hv) || (y >= vv);
            e.hs    = (x >= hv + hf && x < hv + hf + hsw) ? pol : ~pol;
            e.vs    = (y >= vv + vf && y < vv + vf + vsw) ? pol : ~pol;
            stepped = (c - 1 >= div) && ((c - 1) % div == 0);
            e.fs    = stepped && (p % (ht * vt) == 0);
        end
        return e;
    endfunction

    function automatic string fmt(exp_t v);
        return $sformatf("en=%b x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b",
                         v.en, v.x, v.y, v.blank, v.hs, v.vs, v.fs);
    endfunction

    function automatic exp_t sample_a();
        exp_t v;
        v = {ifa.clk25en, ifa.curr_x_pos, ifa.curr_y_pos, ifa.blank,
             ifa.h_sync, ifa.v_sync, ifa.frame_start};
        return v;
    endfunction

    function automatic exp_t sample_b();
        exp_t v;
        v = {ifb.clk25en, ifb.curr_x_pos, ifb.curr_y_pos, ifb.blank,
             ifb.h_sync, ifb.v_sync, ifb.frame_start};
        return v;
    endfunction

    function automatic void chk(string name, exp_t act, exp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s cyc=%0d got %s required %s", name, cyc, fmt(act), fmt(exp));
        end
    endfunction

    function automatic void chk_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(int c, logic en, int x, int y, logic bl,
                                logic hs, logic vs, logic fs);
        vec_t v;
        v.c = c;
        v.e = {en, 10'(x), 10'(y), bl, hs, vs, fs};
        return v;
    endfunction

    // Scoreboard producer: push the model's view of each new clock cycle.
    always @(posedge clk) begin
        int n;
        n = reset ? 0 : cyc + 1;
        cyc <= n;
        qa.push_back(model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
        qb.push_back(model(n, 2, 8, 1, 2, 1, 4, 1, 1, 1, 1'b1));
    end

    // Scoreboard consumer: compare both instances mid-cycle.
    always @(negedge clk) begin
        if (qa.size() > 0) chk("sb_a", sample_a(), qa.pop_front());
        if (qb.size() > 0) chk("sb_b", sample_b(), qb.pop_front());
    end

    bit count_en = 1'b0;
    int a_hs_cnt = 0, a_bl_cnt = 0, a_fs_cnt = 0;
    int b_vs_cnt = 0, b_fs_cnt = 0;

    // Window counters over the first line of (a) and 19 frames of (b).
    always @(negedge clk) begin
        if (count_en && !reset && cyc >= 1 && cyc <= 3200) begin
            if (ifa.h_sync == 1'b0) a_hs_cnt++;
            if (ifa.blank) a_bl_cnt++;
            if (ifa.frame_start) a_fs_cnt++;
        end
        if (count_en && !reset && cyc >= 1 && cyc <= 3192) begin
            if (ifb.v_sync == 1'b1) b_vs_cnt++;
            if (ifb.frame_start) b_fs_cnt++;
        end
    end

    vec_t tbl[13];

    task automatic run_table(string tag);
        int guard;
        for (int i = 0; i < 13; i++) begin
            guard = 0;
            while (cyc < tbl[i].c && guard < 10000) begin
                @(negedge clk);
                guard++;
            end
            if (cyc != tbl[i].c) begin
                checks++;
                errors++;
                $display("FAIL %s_wait entry=%0d got cyc=%0d required %0d", tag, i, cyc, tbl[i].c);
            end else begin
                chk($sformatf("%s_%0d", tag, i), sample_a(), tbl[i].e);
            end
        end
    endtask

    exp_t rst_a, rst_b;

    initial begin
        // Default-timing checkpoints: pixel p occupies cycles 4p+1..4p+4.
        tbl[0]  = mk(1,    1'b0, 0,   0, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[1]  = mk(3,    1'b0, 0,   0, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[2]  = mk(4,    1'b1, 0,   0, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[3]  = mk(5,    1'b0, 1,   0, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[4]  = mk(8,    1'b1, 1,   0, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[5]  = mk(2558, 1'b0, 639, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        tbl[6]  = mk(2562, 1'b0, 640, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        tbl[7]  = mk(2622, 1'b0, 655, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        tbl[8]  = mk(2626, 1'b0, 656, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[9]  = mk(3006, 1'b0, 751, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        tbl[10] = mk(3010, 1'b0, 752, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        tbl[11] = mk(3198, 1'b0, 799, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        tbl[12] = mk(3202, 1'b0, 0,   1, 1'b0, 1'b1, 1'b1, 1'b0);

        rst_a = {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        rst_b = {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};

        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_a", sample_a(), rst_a);
        chk("reset_b", sample_b(), rst_b);

        reset    = 1'b0;
        count_en = 1'b1;
        run_table("line1");
        count_en = 1'b0;

        chk_int("a_hsync_cycles", a_hs_cnt, 384);
        chk_int("a_blank_cycles", a_bl_cnt, 640);
        chk_int("a_frame_start_line", a_fs_cnt, 0);
        chk_int("b_vsync_cycles", b_vs_cnt, 456);
        chk_int("b_frame_starts", b_fs_cnt, 18);

        // Mid-frame reset at x=300 on line 1.
        run_table_mid();
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_a", sample_a(), rst_a);
        chk("midreset_b", sample_b(), rst_b);
        reset = 1'b0;
        run_table("resume");

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic run_table_mid();
        int guard;
        exp_t e;
        guard = 0;
        while (cyc < 4402 && guard < 10000) begin
            @(negedge clk);
            guard++;
        end
        e = {1'b0, 10'd300, 10'd1, 1'b0, 1'b1, 1'b1, 1'b0};
        chk("pre_reset_pos", sample_a(), e);
    endtask

endmodule
